// File: rtl/rr_arb4.sv
// Four-lane round-robin arbiter feeding a single registered output slot.
// The slot is refilled in the same cycle it drains, so throughput is one word per cycle.
module rr_arb4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       v,
  output logic [3:0]       rdy,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [1:0]       sel,
  output logic [7:0]       cnt
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             slot_free;
  logic             found;
  logic             grant;
  logic [1:0]       gidx;
  logic [1:0]       idx;
  logic [WIDTH-1:0] gdata;

  // Search starts one past the last grant; the first valid lane wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && v[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  always_comb begin
    slot_free = !y_valid_q || y_ready;
    grant     = slot_free && found && !reset;
    rdy       = '0;
    if (grant) rdy[gidx] = 1'b1;
  end

  always_comb begin
    unique case (gidx)
      2'd0:    gdata = d0;
      2'd1:    gdata = d1;
      2'd2:    gdata = d2;
      default: gdata = d3;
    endcase
  end

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (grant) begin
      y_d       = gdata;
      y_valid_d = 1'b1;
      sel_d     = gidx;
      ptr_d     = gidx;
      cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 8'd1;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sel_q     <= '0;
      ptr_q     <= 2'd3;
      cnt_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign sel     = sel_q;
  assign cnt     = cnt_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed bench for rr_arb4: reset, round-robin order, backpressure, single lane,
// drain, asynchronous mid-run reset and counter saturation.
module tb_rr_arb4;

  logic       clk;
  logic       reset;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] v;
  logic [3:0] rdy;
  logic [3:0] y;
  logic       y_valid;
  logic       y_ready;
  logic [1:0] sel;
  logic [7:0] cnt;

  int unsigned n_checks;
  int unsigned n_pass;

  rr_arb4 #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .v       (v),
    .rdy     (rdy),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .sel     (sel),
    .cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] lane_d [4];
  logic [3:0] exp_cnt;
  int unsigned sat_exp;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    lane_d[0] = 4'b0000;
    lane_d[1] = 4'b0101;
    lane_d[2] = 4'b1010;
    lane_d[3] = 4'b1111;
    d0 = lane_d[0];
    d1 = lane_d[1];
    d2 = lane_d[2];
    d3 = lane_d[3];
    v       = 4'b1111;
    y_ready = 1'b1;
    reset   = 1'b1;

    // Reset state, with requests pending
    #12;
    check("rst_y",       32'(y),       32'h0);
    check("rst_y_valid", 32'(y_valid), 32'h0);
    check("rst_sel",     32'(sel),     32'h0);
    check("rst_cnt",     32'(cnt),     32'h0);
    check("rst_rdy",     32'(rdy),     32'h0);

    @(negedge clk);
    reset = 1'b0;
    #1;

    // Round robin: grants 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      check("rr_rdy", 32'(rdy), 32'(4'b0001 << (i % 4)));
      step();
      check("rr_y",       32'(y),       32'(lane_d[i % 4]));
      check("rr_sel",     32'(sel),     32'(i % 4));
      check("rr_y_valid", 32'(y_valid), 32'h1);
    end
    check("rr_cnt", 32'(cnt), 32'd5);

    // Lane 1 next, then hold it under backpressure
    check("bp_pre_rdy", 32'(rdy), 32'b0010);
    step();
    check("bp_pre_y", 32'(y), 32'b0101);
    y_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy", 32'(rdy), 32'h0);
      step();
      check("bp_y",       32'(y),       32'b0101);
      check("bp_sel",     32'(sel),     32'd1);
      check("bp_cnt",     32'(cnt),     32'd6);
      check("bp_y_valid", 32'(y_valid), 32'h1);
    end
    y_ready = 1'b1;
    #1;
    check("bp_rel_rdy", 32'(rdy), 32'b0100);
    step();
    check("bp_rel_y",   32'(y),   32'b1010);
    check("bp_rel_sel", 32'(sel), 32'd2);
    check("bp_rel_cnt", 32'(cnt), 32'd7);

    // Single requester on lane 2, granted every cycle
    v = 4'b0100;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("single_rdy", 32'(rdy), 32'b0100);
      step();
      check("single_sel",     32'(sel),     32'd2);
      check("single_y_valid", 32'(y_valid), 32'h1);
    end
    check("single_cnt", 32'(cnt), 32'd13);

    // Drain
    v = 4'b0000;
    #1;
    check("drain_rdy", 32'(rdy), 32'h0);
    step();
    check("drain_y_valid", 32'(y_valid), 32'h0);
    check("drain_y",       32'(y),       32'b1010);
    check("drain_sel",     32'(sel),     32'd2);
    check("drain_cnt",     32'(cnt),     32'd13);
    step();
    check("idle_y_valid", 32'(y_valid), 32'h0);
    check("idle_cnt",     32'(cnt),     32'd13);

    // Mid-run asynchronous reset with a held word (ptr=2, so lane 3 is searched first)
    v       = 4'b1001;
    y_ready = 1'b0;
    #1;
    check("pre_arst_rdy", 32'(rdy), 32'b1000);
    step();
    check("pre_arst_y",   32'(y),   32'b1111);
    check("pre_arst_sel", 32'(sel), 32'd3);
    check("pre_arst_cnt", 32'(cnt), 32'd14);
    #2;
    reset = 1'b1;
    #1;
    check("arst_y",       32'(y),       32'h0);
    check("arst_y_valid", 32'(y_valid), 32'h0);
    check("arst_sel",     32'(sel),     32'h0);
    check("arst_cnt",     32'(cnt),     32'h0);
    check("arst_rdy",     32'(rdy),     32'h0);
    @(negedge clk);
    reset   = 1'b0;
    v       = 4'b1111;
    y_ready = 1'b1;
    #1;
    check("post_arst_rdy", 32'(rdy), 32'b0001);

    // Saturation: lane 1 alone, 260 transfers from a fresh count
    v = 4'b0010;
    #1;
    check("sat_rdy", 32'(rdy), 32'b0010);
    for (int k = 1; k <= 260; k++) begin
      step();
      sat_exp = (k > 255) ? 255 : k;
      if (k >= 250 || k == 1 || k == 128)
        check("sat_cnt", 32'(cnt), 32'(sat_exp));
    end
    check("sat_y",   32'(y),   32'b0101);
    check("sat_sel", 32'(sel), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter WIDTH, default 4: data width of every lane and of the output.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 d0, d1, d2, d3  input  WIDTH each  data of requesters 0..3.
REQ-005 v  input  4  v[i] = requester i presents valid data on d<i>.
REQ-006 rdy  output  4  rdy[i] = requester i's data is accepted this cycle; at most one bit set.
REQ-007 y  output  WIDTH  registered output data.
REQ-008 y_valid  output  1  y holds an undelivered word.
REQ-009 y_ready  input  1  downstream accepts y this cycle.
REQ-010 sel  output  2  registered index of the lane that produced y; drives the downstream 4:1 mux select.
REQ-011 cnt  output  8  registered count of accepted words, saturating.

Function
REQ-012 Transfer in: occurs for lane i when v[i] && rdy[i]; transfer out: occurs when y_valid && y_ready.
REQ-013 slot_free = !y_valid || y_ready; combinational; no input transfer occurs when slot_free is 0.
REQ-014 Pointer ptr (2 bits, internal) holds the last granted lane; search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-015 rdy[i] = slot_free && v[i] && i is the first lane with v set in search order; rdy is all-zero otherwise.
REQ-016 rdy is combinational from v, ptr, y_valid and y_ready; no combinational path from d* to any output.
REQ-017 On an input transfer from lane i, at the next edge: y <= d<i>, sel <= i, y_valid <= 1, ptr <= i, cnt <= cnt+1 unless cnt == 255.
REQ-018 Transfer out with no input transfer in the same cycle: y_valid <= 0; y and sel hold their values.
REQ-019 Simultaneous transfer out and transfer in: the new word replaces y with no bubble; y_valid stays 1.
REQ-020 y_valid && !y_ready: y, sel, y_valid, ptr and cnt hold; rdy is all-zero (backpressure).
REQ-021 No valid requests and slot free: ptr holds; no state other than y_valid (per REQ-018) changes.
REQ-022 Latency: one cycle from an input transfer to the word on y with y_valid = 1.
REQ-023 Throughput: one word per cycle while y_ready stays 1 and any v bit is set.
REQ-024 A single lane requesting continuously is granted every slot-free cycle (work-conserving).
REQ-025 Fairness: with all four v set and y_ready = 1, the grant order is strictly cyclic (0,1,2,3,0,...) after reset.
REQ-026 Requesters may drop v without a transfer; the arbiter keeps no per-lane state besides ptr.
REQ-027 cnt saturates at 255 and never wraps to 0.

Reset
REQ-028 While reset = 1, asynchronously: y = 0, y_valid = 0, sel = 0, cnt = 0, ptr = 3 (lane 0 highest priority first); rdy is all-zero.
REQ-029 Reset asserted mid-transfer discards the word held in y and any grant in progress; operation resumes on the first edge after reset deasserts.

Verification
REQ-030 Reset: assert reset mid-run with y_valid = 1 -> y = 0, y_valid = 0, sel = 0, cnt = 0 immediately, without waiting for clk.
REQ-031 Round-robin: d0 = 0000, d1 = 0101, d2 = 1010, d3 = 1111, v = 1111, y_ready = 1 -> y sequence 0000, 0101, 1010, 1111, 0000 on consecutive cycles; sel sequence 0, 1, 2, 3, 0.
REQ-032 Backpressure: y = 0101 with y_valid = 1, y_ready = 0 for 3 cycles, v = 1111 -> y, sel and cnt hold; rdy = 0000; when y_ready rises, the next grant goes to lane 2 and y = 1010 one cycle later.
REQ-033 Single requester: v = 0100, y_ready = 1 -> rdy = 0100 every cycle; sel = 2; y_valid stays 1; ptr wrap causes no skipped cycles.
REQ-034 Drain: one word in y, v = 0000, y_ready = 1 -> y_valid = 0 next cycle; y and sel keep their last values.
REQ-035 Saturation: 260 accepted transfers -> cnt reads 255 after the 255th transfer and remains 255.
